// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C polling sequencer.
package i2c_pkg;

    localparam int unsigned I2C_BYTES_W = 3;
    localparam int unsigned I2C_DATA_W  = 32;
    localparam int unsigned TMR_W       = 24;

    // Default sensor: 7-bit address and register-pointer command (MSB-first).
    localparam logic [6:0]            DEF_DEV_ADR  = 7'h40;
    localparam logic [I2C_DATA_W-1:0] DEF_CMD_DATA = 32'hE300_0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_ACK,
        ST_WR_WAIT,
        ST_CONV,
        ST_RD_REQ,
        ST_RD_ACK,
        ST_RD_WAIT,
        ST_DONE,
        ST_PERIOD
    } seq_state_t;

endpackage

// File: rtl/i2c_poll_seq_cyc_timer.sv
// Saturating cycle counter: held at zero while cleared, o_done once
// i_limit cycles have elapsed (a limit of 0 behaves as 1).
module cyc_timer
    import i2c_pkg::*;
(
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [TMR_W-1:0] i_limit,
    output logic             o_done
);

    logic [TMR_W-1:0] r_cnt;
    logic [TMR_W-1:0] w_last;

    assign w_last = (i_limit == '0) ? '0 : i_limit - 24'd1;
    assign o_done = (r_cnt >= w_last);

    // Count up from zero while enabled, saturating at all-ones.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

endmodule

// File: rtl/i2c_poll_seq.sv
// Poll sequencer driving an I2C master: pointer write, conversion wait,
// multi-byte read, result strobe; periodic or on trigger.
module i2c_poll_seq
    import i2c_pkg::*;
#(
    parameter logic [6:0]             DEV_ADR     = DEF_DEV_ADR,
    parameter logic [I2C_DATA_W-1:0]  CMD_DATA    = DEF_CMD_DATA,
    parameter logic [I2C_BYTES_W-1:0] CMD_BYTES   = 3'd1,
    parameter logic [I2C_BYTES_W-1:0] RD_BYTES    = 3'd2,
    parameter logic [TMR_W-1:0]       CONV_WAIT   = 24'd5_000_000,
    parameter logic [TMR_W-1:0]       POLL_PERIOD = 24'd10_000_000,
    parameter logic [3:0]             ACK_TMO     = 4'd8
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   enable,
    input  logic                   trig,
    output logic [6:0]             i2c_adr,
    output logic                   i2c_wr,
    output logic                   i2c_rd,
    output logic [I2C_DATA_W-1:0]  i2c_wr_data,
    output logic [I2C_BYTES_W-1:0] i2c_wr_bytes,
    output logic [I2C_BYTES_W-1:0] i2c_rd_bytes,
    input  logic                   i2c_busy,
    input  logic [I2C_DATA_W-1:0]  i2c_rd_data,
    input  logic                   i2c_rd_data_en,
    output logic [I2C_DATA_W-1:0]  result,
    output logic                   result_valid,
    output logic                   err,
    output logic                   seq_busy
);

    seq_state_t            r_state;
    logic                  r_wr;
    logic                  r_rd;
    logic [3:0]            r_ack_cnt;
    logic [I2C_DATA_W-1:0] r_hold;
    logic                  r_got;
    logic [I2C_DATA_W-1:0] r_result;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_seq_busy;
    logic                  w_conv_done;
    logic                  w_per_done;

    assign i2c_adr      = DEV_ADR;
    assign i2c_wr_data  = CMD_DATA;
    assign i2c_wr_bytes = CMD_BYTES;
    assign i2c_rd_bytes = RD_BYTES;
    assign i2c_wr       = r_wr;
    assign i2c_rd       = r_rd;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign err          = r_err;
    assign seq_busy     = r_seq_busy;

    // Timers sit at zero outside their state, so entry always starts from 0.
    cyc_timer u_conv_tmr (
        .clk     (clk),
        .rstb    (rstb),
        .i_clr   (r_state != ST_CONV),
        .i_en    (r_state == ST_CONV),
        .i_limit (CONV_WAIT),
        .o_done  (w_conv_done)
    );

    cyc_timer u_per_tmr (
        .clk     (clk),
        .rstb    (rstb),
        .i_clr   (r_state != ST_PERIOD),
        .i_en    (r_state == ST_PERIOD),
        .i_limit (POLL_PERIOD),
        .o_done  (w_per_done)
    );

    // Sequencer FSM; request pulses and seq_busy are set on the transition
    // into the state they belong to, so they line up with that state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= ST_IDLE;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_ack_cnt  <= '0;
            r_hold     <= '0;
            r_got      <= 1'b0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_seq_busy <= 1'b0;
        end else begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (trig || enable) begin
                        r_state    <= ST_WR_REQ;
                        r_wr       <= 1'b1;
                        r_seq_busy <= 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    r_state   <= ST_WR_ACK;
                    r_ack_cnt <= '0;
                end
                ST_WR_ACK: begin
                    if (i2c_busy) begin
                        r_state <= ST_WR_WAIT;
                    end else if (r_ack_cnt == ACK_TMO) begin
                        r_state    <= ST_IDLE;
                        r_err      <= 1'b1;
                        r_seq_busy <= 1'b0;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 4'd1;
                    end
                end
                ST_WR_WAIT: begin
                    if (!i2c_busy) begin
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (w_conv_done) begin
                        r_state <= ST_RD_REQ;
                        r_rd    <= 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    r_state   <= ST_RD_ACK;
                    r_ack_cnt <= '0;
                end
                ST_RD_ACK: begin
                    if (i2c_busy) begin
                        r_state <= ST_RD_WAIT;
                    end else if (r_ack_cnt == ACK_TMO) begin
                        r_state    <= ST_IDLE;
                        r_err      <= 1'b1;
                        r_seq_busy <= 1'b0;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 4'd1;
                    end
                end
                ST_RD_WAIT: begin
                    if (i2c_rd_data_en) begin
                        r_hold <= i2c_rd_data;
                        r_got  <= 1'b1;
                    end
                    if (!i2c_busy) begin
                        r_seq_busy <= 1'b0;
                        if (r_got) begin
                            r_state    <= ST_DONE;
                            r_seq_busy <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_result   <= r_hold;
                    r_valid    <= 1'b1;
                    r_got      <= 1'b0;
                    r_seq_busy <= 1'b0;
                    r_state    <= enable ? ST_PERIOD : ST_IDLE;
                end
                ST_PERIOD: begin
                    if (trig || (enable && w_per_done)) begin
                        r_state    <= ST_WR_REQ;
                        r_wr       <= 1'b1;
                        r_seq_busy <= 1'b1;
                    end else if (!enable) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_seq_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_poll_seq.sv
// Directed bench for i2c_poll_seq with a behavioural I2C master/slave model.
module tb_i2c_poll_seq;

    localparam int BL = 20;    // master busy length per transaction
    localparam int CW = 100;   // CONV_WAIT
    localparam int PP = 1000;  // POLL_PERIOD
    localparam int AT = 8;     // ACK_TMO

    logic        clk;
    logic        rstb;
    logic        enable;
    logic        trig;
    logic [6:0]  i2c_adr;
    logic        i2c_wr;
    logic        i2c_rd;
    logic [31:0] i2c_wr_data;
    logic [2:0]  i2c_wr_bytes;
    logic [2:0]  i2c_rd_bytes;
    logic        i2c_busy;
    logic [31:0] i2c_rd_data;
    logic        i2c_rd_data_en;
    logic [31:0] result;
    logic        result_valid;
    logic        err;
    logic        seq_busy;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int n_wr = 0, n_rd = 0, n_err = 0, n_valid = 0, viol = 0;
    int wr_cyc = 0, rd_cyc = 0, err_cyc = 0, valid_cyc = 0;
    int wfall = 0, rfall = 0;
    int wr_hist[$];
    bit prev_busy = 1'b0;

    int          mode = 0;  // 0 normal, 1 never busy, 2 no read data
    logic [31:0] slave = 32'h6A5C_0000;
    int          m_cnt;
    bit          m_pend, m_pend_rd, m_is_rd;

    i2c_poll_seq #(
        .CONV_WAIT   (24'd100),
        .POLL_PERIOD (24'd1000),
        .ACK_TMO     (4'd8)
    ) dut (
        .clk            (clk),
        .rstb           (rstb),
        .enable         (enable),
        .trig           (trig),
        .i2c_adr        (i2c_adr),
        .i2c_wr         (i2c_wr),
        .i2c_rd         (i2c_rd),
        .i2c_wr_data    (i2c_wr_data),
        .i2c_wr_bytes   (i2c_wr_bytes),
        .i2c_rd_bytes   (i2c_rd_bytes),
        .i2c_busy       (i2c_busy),
        .i2c_rd_data    (i2c_rd_data),
        .i2c_rd_data_en (i2c_rd_data_en),
        .result         (result),
        .result_valid   (result_valid),
        .err            (err),
        .seq_busy       (seq_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Master model: busy rises the cycle after a request pulse, holds BL
    // cycles; reads present data with rd_data_en in the last busy cycle.
    initial begin
        i2c_busy = 1'b0; i2c_rd_data = '0; i2c_rd_data_en = 1'b0;
        m_cnt = 0; m_pend = 1'b0; m_pend_rd = 1'b0; m_is_rd = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rstb) begin
                i2c_busy = 1'b0; i2c_rd_data_en = 1'b0;
                m_cnt = 0; m_pend = 1'b0; m_pend_rd = 1'b0;
            end else begin
                i2c_rd_data_en = 1'b0;
                if (m_cnt != 0) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 1 && m_is_rd && mode == 0) begin
                        i2c_rd_data_en = 1'b1;
                        i2c_rd_data    = slave;
                    end
                    if (m_cnt == 0) i2c_busy = 1'b0;
                end
                if (m_pend && mode != 1) begin
                    i2c_busy = 1'b1;
                    m_cnt    = BL;
                    m_is_rd  = m_pend_rd;
                end
                m_pend    = i2c_wr | i2c_rd;
                m_pend_rd = i2c_rd;
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (i2c_wr) begin n_wr++; wr_cyc = cyc; wr_hist.push_back(cyc); end
        if (i2c_rd) begin n_rd++; rd_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (result_valid) begin n_valid++; valid_cyc = cyc; end
        if ((i2c_wr && i2c_rd) || ((i2c_wr || i2c_rd) && i2c_busy)) viol++;
        if (prev_busy && !i2c_busy) begin
            if (m_is_rd) rfall = cyc; else wfall = cyc;
        end
        prev_busy = i2c_busy;
    end

    task automatic pulse_trig(output int c);
        trig = 1'b1;
        c = cyc;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic test_reset;
        n_tests++; if (i2c_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr got %b exp 0", i2c_wr); end
        n_tests++; if (i2c_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd got %b exp 0", i2c_rd); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_result got %h exp 0", result); end
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", result_valid); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
        n_tests++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL rst_seq_busy got %b exp 0", seq_busy); end
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++; if (n_wr !== 0) begin n_fail++; $display("FAIL idle_no_wr got %0d exp 0", n_wr); end
        n_tests++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL idle_seq_busy got %b exp 0", seq_busy); end
        n_tests++; if (i2c_adr !== 7'h40) begin n_fail++; $display("FAIL const_adr got %h exp 40", i2c_adr); end
        n_tests++; if (i2c_wr_data !== 32'hE300_0000) begin n_fail++; $display("FAIL const_wr_data got %h exp e3000000", i2c_wr_data); end
        n_tests++; if (i2c_wr_bytes !== 3'd1) begin n_fail++; $display("FAIL const_wr_bytes got %0d exp 1", i2c_wr_bytes); end
        n_tests++; if (i2c_rd_bytes !== 3'd2) begin n_fail++; $display("FAIL const_rd_bytes got %0d exp 2", i2c_rd_bytes); end
    endtask

    task automatic test_trig;
        int tc, w0, r0, v0, e0;
        mode = 0; slave = 32'h6A5C_0000;
        w0 = n_wr; r0 = n_rd; v0 = n_valid; e0 = n_err;
        pulse_trig(tc);
        n_tests++; if (seq_busy !== 1'b1) begin n_fail++; $display("FAIL trig_seq_busy got %b exp 1", seq_busy); end
        for (int i = 0; i < 1500 && n_valid == v0; i++) @(negedge clk);
        repeat (200) @(negedge clk);
        n_tests++; if (n_valid != v0 + 1) begin n_fail++; $display("FAIL trig_valid_cnt got %0d exp %0d", n_valid - v0, 1); end
        n_tests++; if (n_wr != w0 + 1) begin n_fail++; $display("FAIL trig_wr_cnt got %0d exp 1", n_wr - w0); end
        n_tests++; if (n_rd != r0 + 1) begin n_fail++; $display("FAIL trig_rd_cnt got %0d exp 1", n_rd - r0); end
        n_tests++; if (wr_cyc != tc + 1) begin n_fail++; $display("FAIL trig_wr_lat got %0d exp %0d", wr_cyc - tc, 1); end
        n_tests++; if (rd_cyc != wfall + CW + 1) begin n_fail++; $display("FAIL trig_rd_delay got %0d exp %0d", rd_cyc - wfall, CW + 1); end
        n_tests++; if (valid_cyc != rfall + 2) begin n_fail++; $display("FAIL trig_valid_lat got %0d exp 2", valid_cyc - rfall); end
        n_tests++; if (result !== 32'h6A5C_0000) begin n_fail++; $display("FAIL trig_result got %h exp 6a5c0000", result); end
        n_tests++; if (n_err != e0) begin n_fail++; $display("FAIL trig_err got %0d exp 0", n_err - e0); end
        n_tests++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL trig_end_seq_busy got %b exp 0", seq_busy); end
    endtask

    task automatic test_poll;
        int w0, e0, v0, n0;
        mode = 0; slave = 32'h6A5C_0000;
        w0 = wr_hist.size(); e0 = n_err; v0 = n_valid;
        enable = 1'b1;
        for (int i = 0; i < 5000 && wr_hist.size() < w0 + 3; i++) @(negedge clk);
        n_tests++;
        if (wr_hist.size() < w0 + 3) begin
            n_fail++; $display("FAIL poll_wr_cnt got %0d exp 3", wr_hist.size() - w0);
        end else begin
            if (wr_hist[w0+1] - wr_hist[w0] != 2*BL + 1105) begin
                n_fail++; $display("FAIL poll_spacing1 got %0d exp %0d", wr_hist[w0+1] - wr_hist[w0], 2*BL + 1105);
            end
            n_tests++;
            if (wr_hist[w0+2] - wr_hist[w0+1] != 2*BL + 1105) begin
                n_fail++; $display("FAIL poll_spacing2 got %0d exp %0d", wr_hist[w0+2] - wr_hist[w0+1], 2*BL + 1105);
            end
        end
        n_tests++; if (n_valid < v0 + 2) begin n_fail++; $display("FAIL poll_valid_cnt got %0d exp >=2", n_valid - v0); end
        enable = 1'b0;
        repeat (3000) @(negedge clk);
        n_tests++; if (n_err != e0) begin n_fail++; $display("FAIL poll_err got %0d exp 0", n_err - e0); end
        n_tests++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL poll_stop_seq_busy got %b exp 0", seq_busy); end
        n0 = n_wr;
        repeat (1300) @(negedge clk);
        n_tests++; if (n_wr != n0) begin n_fail++; $display("FAIL poll_stopped got %0d exp 0", n_wr - n0); end
    endtask

    task automatic test_ack_timeout;
        int tc, e0, v0, r0;
        mode = 1;
        e0 = n_err; v0 = n_valid; r0 = n_rd;
        pulse_trig(tc);
        for (int i = 0; i < 100 && n_err == e0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_tests++; if (n_err != e0 + 1) begin n_fail++; $display("FAIL tmo_err_cnt got %0d exp 1", n_err - e0); end
        n_tests++; if (err_cyc - wr_cyc != AT + 2) begin n_fail++; $display("FAIL tmo_err_lat got %0d exp %0d", err_cyc - wr_cyc, AT + 2); end
        n_tests++; if (n_valid != v0 || n_rd != r0) begin n_fail++; $display("FAIL tmo_no_read got valid %0d rd %0d exp 0 0", n_valid - v0, n_rd - r0); end
        n_tests++; if (result !== 32'h6A5C_0000) begin n_fail++; $display("FAIL tmo_result got %h exp 6a5c0000", result); end
        n_tests++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_seq_busy got %b exp 0", seq_busy); end
        mode = 0;
    endtask

    task automatic test_no_data;
        int tc, e0, v0;
        mode = 2; slave = 32'hDEAD_0000;
        e0 = n_err; v0 = n_valid;
        pulse_trig(tc);
        for (int i = 0; i < 1500 && n_err == e0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_tests++; if (n_err != e0 + 1) begin n_fail++; $display("FAIL nodata_err_cnt got %0d exp 1", n_err - e0); end
        n_tests++; if (n_valid != v0) begin n_fail++; $display("FAIL nodata_valid got %0d exp 0", n_valid - v0); end
        n_tests++; if (result !== 32'h6A5C_0000) begin n_fail++; $display("FAIL nodata_result got %h exp 6a5c0000", result); end
        n_tests++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL nodata_seq_busy got %b exp 0", seq_busy); end
        mode = 0;
    endtask

    task automatic test_trig_ignore_period;
        int tc, w0, v0, e0, wf0;
        mode = 0; slave = 32'h1357_0000;
        w0 = n_wr; v0 = n_valid; e0 = n_err; wf0 = wfall;
        enable = 1'b1;
        for (int i = 0; i < 200 && wfall == wf0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        pulse_trig(tc);
        for (int i = 0; i < 1500 && n_valid == v0; i++) @(negedge clk);
        n_tests++; if (n_wr != w0 + 1) begin n_fail++; $display("FAIL conv_trig_ignored got %0d exp 1", n_wr - w0); end
        n_tests++; if (result !== 32'h1357_0000) begin n_fail++; $display("FAIL conv_result got %h exp 13570000", result); end
        repeat (50) @(negedge clk);
        pulse_trig(tc);
        for (int i = 0; i < 10 && n_wr == w0 + 1; i++) @(negedge clk);
        n_tests++; if (wr_cyc != tc + 1) begin n_fail++; $display("FAIL period_trig_lat got %0d exp 1", wr_cyc - tc); end
        enable = 1'b0;
        repeat (600) @(negedge clk);
        n_tests++; if (seq_busy !== 1'b0 || n_err != e0) begin n_fail++; $display("FAIL period_end got seq_busy %b err %0d exp 0 0", seq_busy, n_err - e0); end
    endtask

    task automatic test_reset_midread;
        int tc, r0, v0, e0;
        mode = 0; slave = 32'h2468_0000;
        r0 = n_rd;
        pulse_trig(tc);
        for (int i = 0; i < 500 && n_rd == r0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_tests++; if (i2c_busy !== 1'b1) begin n_fail++; $display("FAIL mid_read_busy got %b exp 1", i2c_busy); end
        rstb = 1'b0;
        #1;
        n_tests++; if (i2c_wr !== 1'b0 || i2c_rd !== 1'b0) begin n_fail++; $display("FAIL arst_req got wr %b rd %b exp 0 0", i2c_wr, i2c_rd); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL arst_result got %h exp 0", result); end
        n_tests++; if (result_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL arst_strobes got valid %b err %b exp 0 0", result_valid, err); end
        n_tests++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL arst_seq_busy got %b exp 0", seq_busy); end
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        v0 = n_valid; e0 = n_err;
        pulse_trig(tc);
        for (int i = 0; i < 1500 && n_valid == v0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_tests++; if (n_valid != v0 + 1) begin n_fail++; $display("FAIL post_rst_valid got %0d exp 1", n_valid - v0); end
        n_tests++; if (result !== 32'h2468_0000) begin n_fail++; $display("FAIL post_rst_result got %h exp 24680000", result); end
        n_tests++; if (n_err != e0) begin n_fail++; $display("FAIL post_rst_err got %0d exp 0", n_err - e0); end
    endtask

    task automatic test_protocol;
        n_tests++; if (viol != 0) begin n_fail++; $display("FAIL req_overlap got %0d exp 0", viol); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got cycle %0d exp finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rstb = 1'b0; enable = 1'b0; trig = 1'b0;
        @(negedge clk);
        test_reset();
        test_trig();
        test_poll();
        test_ack_timeout();
        test_no_data();
        test_trig_ignore_period();
        test_reset_midread();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
